dbg_scan_ctrl: RTL and testbench
================================

Name: dbg_scan_ctrl

Overview:
Parametrised debug-inspection sequencer for the single-cycle CPU's seven-segment debug path. It replaces the per-source ad-hoc scan counters for register file, data memory, ALU probes and LED pattern ROM with one engine. The engine keeps an independent wrap-around read pointer per channel, issues reads to a shared registered read port, and latches the returned word for display. Advance comes from an internal clock-enable tick in auto mode or from a debounced-by-sync step button in step mode; it replaces the divided CPU clock.

Parameters:
NCH, 4, number of inspectable channels (2..8)
DW, 32, data width per channel
AW, 6, pointer/address width
DIV_FAST, 25, fast auto tick period = 2^DIV_FAST clk cycles
DIV_SLOW, 27, slow auto tick period = 2^DIV_SLOW clk cycles (DIV_SLOW >= DIV_FAST)
RD_LAT, 1, source read latency in clk cycles (1..3)

Ports:
clk  in  1  system clock
rstn  in  1  reset; synchronous, active-high (asserted = 1)
ch_sel  in  CSW=$clog2(NCH)  selected channel
mode  in  2  00 hold, 01 auto, 10 step, 11 rewind
slow  in  1  auto rate select: 1 = DIV_SLOW, 0 = DIV_FAST
step_btn  in  1  asynchronous step button
ch_depth  in  NCH*AW  last valid index per channel, channel i at [i*AW +: AW]
rd_en  out  1  read strobe, one cycle
rd_ch  out  CSW  channel being read
rd_addr  out  AW  address being read
rd_data  in  NCH*DW  per-channel read data, valid RD_LAT cycles after rd_en
disp_data  out  DW  latched display word
disp_addr  out  AW  address of disp_data
disp_valid  out  1  disp_data belongs to the current ch_sel
missed  out  1  sticky: an advance arrived while busy
tick_o  out  1  one-cycle auto tick pulse (debug)

Behaviour:
- Reset, when rstn=1 at a clk edge: all pointers 0; prescaler 0; FSM IDLE; rd_en, disp_valid, missed and tick_o 0; disp_data, disp_addr, rd_ch and rd_addr 0; button synchroniser 0. Reset dominates everything, including a read in flight: its data is discarded.
- Prescaler: free-running DIV_SLOW-bit counter. tick = low DIV_FAST bits (slow=0) or all DIV_SLOW bits (slow=1) all ones. tick_o mirrors tick in every mode.
- Step: step_btn passes a 2-FF synchroniser plus an edge register. advance_step = rising edge of the synchronised signal, so there are 3 cycles from pin to pulse. A held button gives exactly one advance.
- advance = (mode==01 & tick) | (mode==10 & advance_step). In mode 00, advances are ignored and the display is held.
- mode 11 (rewind): every cycle, all pointers forced to 0 and missed cleared. No reads are issued. disp_* are unchanged.
- FSM:
  - IDLE: on advance, go to ISSUE.
  - ISSUE: one cycle; rd_en=1, rd_ch=ch_sel, rd_addr=ptr[ch_sel]. Pointer post-increments; if ptr == ch_depth[ch] it wraps to 0. Go to WAIT.
  - WAIT: count RD_LAT-1 cycles, then go to CAPTURE.
  - CAPTURE: disp_data <= rd_data slice rd_ch; disp_addr <= issued address. disp_valid <= (rd_ch == ch_sel). Go to IDLE.
  - Total latency: disp_data updates RD_LAT+1 cycles after the ISSUE cycle.
- Advance during ISSUE, WAIT or CAPTURE is dropped and sets missed. Advance in IDLE on the same cycle as CAPTURE completes cannot occur, because CAPTURE returns to IDLE.
- ch_sel change: disp_valid cleared on the next cycle. Pointers of other channels are retained. A read in flight for the old channel still captures, with disp_valid=0.
- ch_depth = 0 for a channel: that pointer stays 0 (single entry).
- The issue address is ptr, not ptr+1. The first advance after reset shows index 0. This differs from the old pre-increment counters, which skipped entry 0.

Test Plan:
- Reset mid-read: DIV_FAST=2, mode=01, rstn pulsed during WAIT with RD_LAT=3 -> disp_valid=0, pointers 0, no capture. Next tick issues rd_addr=0.
- Auto scan wrap: NCH=4, ch_sel=1, ch_depth[1]=2, mode=01, slow=0, DIV_FAST=3; source returns addr+0x100 -> rd_en every 8 cycles; disp_data sequence 0x100,0x101,0x102,0x100. Each update lands RD_LAT+1 cycles after rd_en.
- Step mode: mode=10, step_btn held high for 50 cycles -> exactly one rd_en, 3 cycles after the pin rises; second press -> next address.
- Missed advance: RD_LAT=3, two step edges 2 cycles apart -> one read; missed=1. mode=11 for one cycle -> missed=0, all pointers 0.
- Channel switch: advance ch0 to ptr=5, switch to ch2, advance twice, return to ch0 -> next read of ch0 is rd_addr=5. disp_valid=0 immediately after each switch until the first capture.
- Hold/slow: mode=00 for 2^DIV_SLOW cycles -> no rd_en, tick_o still pulses. mode=01, slow=1 -> rd_en period 2^DIV_SLOW.

Source files
------------

// File: rtl/dbg_scan_ctrl.sv
// Debug-inspection sequencer: per-channel wrap-around read pointers, one shared
// registered read port, and a latched display word advanced by auto tick or step button.
module dbg_scan_ctrl #(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int AW       = 6,
  parameter int DIV_FAST = 25,
  parameter int DIV_SLOW = 27,
  parameter int RD_LAT   = 1,
  localparam int CSW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CSW-1:0]    ch_sel,
  input  logic [1:0]        mode,
  input  logic              slow,
  input  logic              step_btn,
  input  logic [NCH*AW-1:0] ch_depth,
  output logic              rd_en,
  output logic [CSW-1:0]    rd_ch,
  output logic [AW-1:0]     rd_addr,
  input  logic [NCH*DW-1:0] rd_data,
  output logic [DW-1:0]     disp_data,
  output logic [AW-1:0]     disp_addr,
  output logic              disp_valid,
  output logic              missed,
  output logic              tick_o
);

  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_REWIND = 2'b11;
  localparam logic [1:0] WAIT_LAST   = 2'(RD_LAT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t              state;
  state_t              state_n;
  logic [DIV_SLOW-1:0] pre;
  logic                tick;
  logic                btn_s1;
  logic                btn_s2;
  logic                btn_s3;
  logic                advance_step;
  logic                advance;
  logic [AW-1:0]       ptr [NCH];
  logic [1:0]          wait_cnt;
  logic [CSW-1:0]      ch_sel_q;
  logic [AW-1:0]       cur_depth;

  assign tick         = slow ? (&pre) : (&pre[DIV_FAST-1:0]);
  assign tick_o       = tick;
  assign advance_step = btn_s2 & ~btn_s3;
  assign advance      = ((mode == MODE_AUTO) && tick) || ((mode == MODE_STEP) && advance_step);
  assign cur_depth    = ch_depth[rd_ch*AW +: AW];

  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    case (state)
      IDLE:    if (advance) state_n = ISSUE;
      ISSUE: begin
        rd_en   = 1'b1;
        state_n = (RD_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT:    if (wait_cnt == WAIT_LAST) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= IDLE;
      pre        <= '0;
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_s3     <= 1'b0;
      ch_sel_q   <= '0;
      wait_cnt   <= '0;
      rd_ch      <= '0;
      rd_addr    <= '0;
      disp_data  <= '0;
      disp_addr  <= '0;
      disp_valid <= 1'b0;
      missed     <= 1'b0;
      for (int i = 0; i < NCH; i++) ptr[i] <= '0;
    end else begin
      state    <= state_n;
      pre      <= pre + 1'b1;
      btn_s1   <= step_btn;
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      ch_sel_q <= ch_sel;

      // Address and channel are frozen for the whole transaction.
      if (state == IDLE && advance) begin
        rd_ch   <= ch_sel;
        rd_addr <= ptr[ch_sel];
      end

      if (state == ISSUE) begin
        wait_cnt    <= '0;
        ptr[rd_ch]  <= (ptr[rd_ch] == cur_depth) ? '0 : ptr[rd_ch] + 1'b1;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == CAPTURE) begin
        disp_data  <= rd_data[rd_ch*DW +: DW];
        disp_addr  <= rd_addr;
        disp_valid <= (rd_ch == ch_sel);
      end else if (ch_sel != ch_sel_q) begin
        disp_valid <= 1'b0;
      end

      if (advance && state != IDLE) missed <= 1'b1;

      // Rewind overrides any pointer update from an in-flight issue.
      if (mode == MODE_REWIND) begin
        missed <= 1'b0;
        for (int i = 0; i < NCH; i++) ptr[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Directed bench for dbg_scan_ctrl: step-mode vector table plus hand sequences for
// channel switching, missed advances, rewind, auto scan, reset mid-read and hold/slow.
module tb_dbg_scan_ctrl;

  localparam int NCH      = 4;
  localparam int DW       = 32;
  localparam int AW       = 6;
  localparam int CSW      = 2;
  localparam int DIV_FAST = 3;
  localparam int DIV_SLOW = 5;
  localparam int RD_LAT   = 3;

  logic              clk;
  logic              rstn;
  logic [CSW-1:0]    ch_sel;
  logic [1:0]        mode;
  logic              slow;
  logic              step_btn;
  logic [NCH*AW-1:0] ch_depth;
  logic              rd_en;
  logic [CSW-1:0]    rd_ch;
  logic [AW-1:0]     rd_addr;
  logic [NCH*DW-1:0] rd_data;
  logic [DW-1:0]     disp_data;
  logic [AW-1:0]     disp_addr;
  logic              disp_valid;
  logic              missed;
  logic              tick_o;

  dbg_scan_ctrl #(
    .NCH(NCH), .DW(DW), .AW(AW), .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .ch_sel(ch_sel), .mode(mode), .slow(slow),
    .step_btn(step_btn), .ch_depth(ch_depth), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_data(rd_data), .disp_data(disp_data),
    .disp_addr(disp_addr), .disp_valid(disp_valid), .missed(missed), .tick_o(tick_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source model: registered read port, data lands RD_LAT cycles after rd_en.
  logic          pv [RD_LAT] = '{default: 1'b0};
  logic [AW-1:0] pa [RD_LAT] = '{default: '0};
  logic [AW-1:0] src_a = '1;

  always @(posedge clk) begin
    pv[0] <= rd_en;
    pa[0] <= rd_addr;
    for (int j = 1; j < RD_LAT; j++) begin
      pv[j] <= pv[j-1];
      pa[j] <= pa[j-1];
    end
    if (pv[RD_LAT-2]) src_a <= pa[RD_LAT-2];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++)
      rd_data[i*DW +: DW] = 32'h100 + (32'(i) << 12) + 32'(src_a);
  end

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] last_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick(2);
    rstn = 1'b0;
  endtask

  task automatic wait_rd(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick(1);
      n++;
      seen = rd_en;
    end
    check("rd_en_timeout", seen, 1'b1);
  endtask

  // One step-mode read of channel ch with full latency and result checks.
  task automatic do_step(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int  n;
    bit  seen;
    bit  changed;
    changed = (CSW'(ch) != ch_sel);
    ch_sel  = CSW'(ch);
    tick(1);
    if (changed) check("valid_clr_on_switch", disp_valid, 1'b0);
    step_btn = 1'b1;
    wait_rd(10, n, seen);
    if (seen) begin
      check("step_latency", n, 3);
      check("rd_addr", rd_addr, addr);
      check("rd_ch", rd_ch, ch);
      tick(RD_LAT);
      check("disp_not_early", disp_data, last_data);
      tick(1);
      check("disp_data", disp_data, data);
      check("disp_addr", disp_addr, addr);
      check("disp_valid", disp_valid, 1'b1);
      last_data = data;
    end
    step_btn = 1'b0;
    tick(3);
  endtask

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int  n;
    int  cnt;
    int  cnt2;
    int  t0;
    bit  seen;

    // depths: ch0=7, ch1=2, ch2=3, ch3=0
    vecs[0]  = '{1, 6'd0, 32'h1100};
    vecs[1]  = '{1, 6'd1, 32'h1101};
    vecs[2]  = '{1, 6'd2, 32'h1102};
    vecs[3]  = '{1, 6'd0, 32'h1100};
    vecs[4]  = '{0, 6'd0, 32'h0100};
    vecs[5]  = '{0, 6'd1, 32'h0101};
    vecs[6]  = '{3, 6'd0, 32'h3100};
    vecs[7]  = '{3, 6'd0, 32'h3100};
    vecs[8]  = '{2, 6'd0, 32'h2100};
    vecs[9]  = '{0, 6'd2, 32'h0102};
    vecs[10] = '{1, 6'd1, 32'h1101};

    rstn     = 1'b0;
    ch_sel   = '0;
    mode     = 2'b00;
    slow     = 1'b0;
    step_btn = 1'b0;
    ch_depth = {6'd0, 6'd3, 6'd2, 6'd7};
    tick(1);
    do_reset();

    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_ch", rd_ch, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_disp_addr", disp_addr, 0);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_missed", missed, 1'b0);
    check("rst_tick_o", tick_o, 1'b0);

    // step-mode vector table
    mode = 2'b10;
    for (int i = 0; i < 11; i++) do_step(vecs[i].ch, vecs[i].addr, vecs[i].data);

    // held button: exactly one read
    ch_sel = 2'd0;
    tick(1);
    step_btn = 1'b1;
    cnt = 0;
    t0 = -1;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (rd_en) begin
        cnt++;
        if (t0 < 0) t0 = i;
        check("held_rd_addr", rd_addr, 3);
      end
    end
    check("held_rd_count", cnt, 1);
    check("held_latency", t0, 3);
    step_btn = 1'b0;
    tick(4);
    last_data = 32'h0103;

    // in-flight read captured after switching away: valid stays low
    step_btn = 1'b1;
    wait_rd(10, n, seen);
    check("inflight_rd_addr", rd_addr, 4);
    ch_sel = 2'd2;
    tick(1);
    check("inflight_valid_clr", disp_valid, 1'b0);
    tick(RD_LAT);
    check("inflight_disp_data", disp_data, 32'h0104);
    check("inflight_disp_valid", disp_valid, 1'b0);
    last_data = 32'h0104;
    step_btn = 1'b0;
    tick(4);
    do_step(2, 6'd1, 32'h2101);
    do_step(2, 6'd2, 32'h2102);
    do_step(0, 6'd5, 32'h0105);

    // two step edges two cycles apart while busy
    step_btn = 1'b1;
    tick(1);
    step_btn = 1'b0;
    tick(1);
    step_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (rd_en) cnt++;
    end
    check("missed_rd_count", cnt, 1);
    check("missed_set", missed, 1'b1);
    step_btn = 1'b0;
    tick(4);
    last_data = 32'h0106;

    // rewind: pointers to 0, missed cleared, display held
    mode = 2'b11;
    tick(1);
    check("rewind_missed", missed, 1'b0);
    check("rewind_disp_held", disp_data, 32'h0106);
    mode = 2'b10;
    tick(2);
    do_step(0, 6'd0, 32'h0100);
    do_step(1, 6'd0, 32'h1100);
    check("missed_stays_clear", missed, 1'b0);

    // auto scan with wrap on ch1
    mode = 2'b00;
    ch_sel = 2'd1;
    do_reset();
    mode = 2'b01;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_rd(20, n, seen);
      check("auto_period", cyc - t0, 8);
      t0 = cyc;
      check("auto_rd_addr", rd_addr, (i == 3) ? 0 : i);
      tick(RD_LAT + 1);
      check("auto_disp_data", disp_data, (i == 3) ? 32'h1100 : 32'h1100 + i);
    end

    // reset during WAIT discards the in-flight read
    wait_rd(20, n, seen);
    check("midrst_rd_addr", rd_addr, 1);
    tick(1);
    rstn = 1'b1;
    tick(1);
    rstn = 1'b0;
    t0 = cyc;
    tick(5);
    check("midrst_disp_data", disp_data, 0);
    check("midrst_disp_valid", disp_valid, 1'b0);
    wait_rd(20, n, seen);
    check("midrst_first_tick", cyc - t0, 8);
    check("midrst_rd_addr0", rd_addr, 0);

    // hold mode: ticks continue, no reads
    mode = 2'b00;
    tick(6);
    cnt = 0;
    cnt2 = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (rd_en) cnt++;
      if (tick_o) cnt2++;
    end
    check("hold_no_reads", cnt, 0);
    check("hold_fast_ticks", cnt2, 4);
    slow = 1'b1;
    cnt2 = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (rd_en) cnt++;
      if (tick_o) cnt2++;
    end
    check("hold_no_reads_slow", cnt, 0);
    check("hold_slow_ticks", cnt2, 1);

    // slow auto rate
    mode = 2'b01;
    wait_rd(40, n, seen);
    t0 = cyc;
    wait_rd(40, n, seen);
    check("slow_period", cyc - t0, 32);
    mode = 2'b00;
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
